// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle sequencer: states, opcodes, mux selects.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package multicycle_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        EXEC_R    = 4'd3,
        R_WB      = 4'd4,
        EXEC_I    = 4'd5,
        I_WB      = 4'd6,
        MEM_ADDR  = 4'd7,
        MEM_READ  = 4'd8,
        MEM_WB    = 4'd9,
        MEM_WRITE = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        HALT      = 4'd13,
        ERROR     = 4'd14
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that sit waiting on the memory handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)    || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory wait state; flags the last tolerated one.
// Latency: expired is combinational from the count register.
// Backpressure: none; saturates instead of wrapping when the limit is disabled.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic expired
);
    localparam int CW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the 16-bit multicycle datapath, with a memory-wait timeout trap.
// Latency: R/addi 4, lw 5, sw 4, beq 3, j 3 cycles with zero-wait memory.
// Backpressure: FETCH/MEM_READ/MEM_WRITE hold until mem_ready, trapping to ERROR on timeout.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           branchCond,
    output logic [1:0]     PCSource,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           RegWrite,
    output logic           RegDst,
    output logic           MemToReg,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic           illegal_op,
    output logic           halted,
    output logic           bus_error,
    output logic [3:0]     state
);
    state_t state_q;
    state_t state_nxt;
    logic   timer_clear;
    logic   timer_advance;
    logic   timer_expired;

    assign timer_clear   = (state_nxt != state_q);
    assign timer_advance = is_wait_state(state_q) && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .advance (timer_advance),
        .expired (timer_expired)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:      state_nxt = FETCH;
            FETCH:     if (mem_ready) state_nxt = DECODE;
                       else if (timer_expired) state_nxt = ERROR;
            DECODE: begin
                case (opcode)
                    OP_RTYPE: state_nxt = EXEC_R;
                    OP_ADDI:  state_nxt = EXEC_I;
                    OP_LW,
                    OP_SW:    state_nxt = MEM_ADDR;
                    OP_BEQ:   state_nxt = BRANCH;
                    OP_J:     state_nxt = JUMP;
                    OP_HALT:  state_nxt = HALT;
                    default:  state_nxt = FETCH;
                endcase
            end
            EXEC_R:    state_nxt = R_WB;
            R_WB:      state_nxt = FETCH;
            EXEC_I:    state_nxt = I_WB;
            I_WB:      state_nxt = FETCH;
            MEM_ADDR:  state_nxt = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (mem_ready) state_nxt = MEM_WB;
                       else if (timer_expired) state_nxt = ERROR;
            MEM_WB:    state_nxt = FETCH;
            MEM_WRITE: if (mem_ready) state_nxt = FETCH;
                       else if (timer_expired) state_nxt = ERROR;
            BRANCH:    state_nxt = FETCH;
            JUMP:      state_nxt = FETCH;
            HALT:      state_nxt = HALT;
            ERROR:     state_nxt = ERROR;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign state = state_q;

    // Decode from the state register; only FETCH's IR/PC loads look at mem_ready.
    always_comb begin
        PCWrite    = 1'b0;
        branchCond = 1'b0;
        PCSource   = PCSRC_ALU;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        ALUOp      = ALUOP_ADD;
        illegal_op = 1'b0;
        halted     = 1'b0;
        bus_error  = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_ONE;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB    = SRCB_BROFF;
                illegal_op = !is_legal_op(opcode);
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            EXEC_I, MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            I_WB:      RegWrite = 1'b1;
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_SUB;
                branchCond = 1'b1;
                PCSource   = PCSRC_ALUOUT;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            HALT:      halted    = 1'b1;
            ERROR:     bus_error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style sequencer for the 16-bit multicycle datapath.
- Drives PC write enables (PCWrite, branchCond), IR load, memory strobes, register-file write and ALU/mux selects, one instruction at a time.
- Sits beside the PC, IR, register file and ALU. Takes the opcode from IR and a mem_ready handshake from memory.
- Adds a memory-wait timeout that traps to an error state.

Parameters:
- OPW, 4, opcode width.
- MEM_TIMEOUT, 16, consecutive not-ready cycles tolerated in a memory state before trapping; 0 disables the timeout.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high; forces IDLE
- opcode  input  4  IR[15:12]; valid from DECODE onward
- mem_ready  input  1  memory access completes this cycle
- PCWrite  output  1  unconditional PC load
- branchCond  output  1  PC load qualified by ALU isZero
- PCSource  output  2  PC mux: 00 ALU result, 01 ALUOut (branch target), 10 jump target
- IorD  output  1  memory address: 0 PC, 1 ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  IR load
- RegWrite  output  1  register-file write
- RegDst  output  1  destination: 0 rt, 1 rd
- MemToReg  output  1  write-back source: 0 ALUOut, 1 MDR
- ALUSrcA  output  1  0 PC, 1 regA
- ALUSrcB  output  2  00 regB, 01 constant 1, 10 sign-extended immediate, 11 sign-extended branch offset
- ALUOp  output  2  00 add, 01 subtract, 10 funct-decoded
- illegal_op  output  1  one-cycle pulse on undefined opcode
- halted  output  1  high while in HALT
- bus_error  output  1  high while in ERROR
- state  output  4  current state encoding, for debug

Behaviour:
- Reset (asynchronous): state=IDLE, timeout counter=0, every output 0. On release, IDLE->FETCH on the next edge.
- Outputs decode from the state register only, except IRWrite/PCWrite in FETCH, which are also gated by mem_ready.
- Any output not listed for a state is 0.
- Opcodes: 0000 R-type, 0001 addi, 0010 lw, 0011 sw, 0100 beq, 0101 j, 1111 halt; all others illegal.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - mem_ready=1: IRWrite=1, PCWrite=1, next DECODE.
  - mem_ready=0: stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target).
  - Next state: R-type->EXEC_R; addi->EXEC_I; lw/sw->MEM_ADDR; beq->BRANCH; j->JUMP; halt->HALT.
  - Illegal opcode: illegal_op=1, next FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemToReg=0 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> I_WB.
- I_WB: RegWrite=1, RegDst=0, MemToReg=0 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: MemRead=1, IorD=1; stay until mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemToReg=1 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1; stay until mem_ready, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, branchCond=1, PCSource=01 -> FETCH. The PC loads only if isZero.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- HALT: halted=1, all strobes 0; held until reset.
- ERROR: bus_error=1, all strobes 0; held until reset.
- Timeout counter (wait states FETCH, MEM_READ, MEM_WRITE):
  - Cleared on every state change.
  - In a wait state with mem_ready=0: if count==MEM_TIMEOUT-1, next state is ERROR; otherwise count+1.
  - With MEM_TIMEOUT=16: 16 consecutive not-ready cycles, then ERROR on the 17th edge.
  - mem_ready=1 in the same cycle as the limit: mem_ready wins.
  - Width is clog2(MEM_TIMEOUT)+1; no wrap.
- Asynchronous reset mid-instruction: immediate IDLE with all outputs 0, including in HALT and ERROR.
- Latency in cycles, zero-wait memory: R/addi 4, lw 5, sw 4, beq 3, j 3.

Decomposition:
- Package multicycle_pkg holds:
  - state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, R_WB=4, EXEC_I=5, I_WB=6, MEM_ADDR=7, MEM_READ=8, MEM_WB=9, MEM_WRITE=10, BRANCH=11, JUMP=12, HALT=13, ERROR=14;
  - opcode constants;
  - ALUOp, ALUSrcB and PCSource select constants.
- Sub-module mem_wait_timer: counter, clear, and expired flag.
- Next-state logic and output decode stay in this module.

Test Plan:
- Reset asserted mid-MEM_READ -> all outputs 0, state=0 immediately, no clock edge needed; after release, FETCH (1) follows one cycle later.
- addi, mem_ready tied 1 -> state sequence 1,2,5,6,1. IRWrite=PCWrite=1 only in FETCH; RegWrite=1, RegDst=0 only in I_WB.
- lw with mem_ready low 3 cycles in MEM_READ -> state stays 8 for 4 cycles, then MEM_WB with RegWrite=1, MemToReg=1. Total 8 cycles from FETCH.
- beq -> BRANCH with branchCond=1, PCSource=01, ALUOp=01, PCWrite=0. j -> JUMP with PCWrite=1, PCSource=10.
- Opcode 0111 -> illegal_op pulses exactly 1 cycle in DECODE, next FETCH. Opcode 1111 -> halted=1, held for 100 cycles until reset.
- FETCH with mem_ready=0 for 16 cycles -> state=14, bus_error=1. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no error.
